// File: rtl/mdr_pkg.sv
// mdr_pkg: shared FSM state type and default sizes for the buffered memory data register
package mdr_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF = 4;
endpackage

// File: rtl/mdr_buffered_if.sv
// mdr_buffered_if: req/ack memory port between the data register (master) and memory (slave)
interface mdr_buffered_if #(parameter int DATA_W = 16);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  modport master (output req, we, wdata, input rdata, ack);
  modport slave (input req, we, wdata, output rdata, ack);
endinterface

// File: rtl/mdr_wfifo.sv
// mdr_wfifo: posted-write FIFO; a push into a full FIFO is accepted when a pop happens the same cycle
module mdr_wfifo
  import mdr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic              ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              do_push, do_pop;
  logic [DATA_W-1:0] mem_q [DEPTH];
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign ovf     = ovf_q;
  // next pointers wrap naturally because DEPTH is a power of two; overflow is sticky
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    ovf_d    = ovf_q | (push & ~do_push);
  end
  // control state with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end
  // storage needs no reset; only entries below the occupancy count are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/mdr_buffered.sv
// mdr_buffered: memory data register posting bus writes through a FIFO and ordering reads behind them
module mdr_buffered
  import mdr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [DATA_W-1:0] bus,
  input  logic              bus_oe,
  input  logic              wr_load,
  input  logic              rd_start,
  output logic              rd_valid,
  output logic              wr_full,
  output logic              wr_empty,
  output logic              wr_ovf,
  output logic              busy,
  mdr_buffered_if.master    mem
);
  state_t            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d, rd_pend_q, rd_pend_d;
  logic              pop, ack;
  logic [DATA_W-1:0] head;
  mdr_wfifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_wfifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_load),
    .pop   (pop),
    .din   (bus),
    .head  (head),
    .full  (wr_full),
    .empty (wr_empty),
    .ovf   (wr_ovf)
  );
  assign ack       = mem.ack & req_q;
  assign bus       = bus_oe ? rd_data_q : {DATA_W{1'bz}};
  assign busy      = (state_q != IDLE) | rd_pend_q | ~wr_empty;
  assign rd_valid  = rd_valid_q;
  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.wdata = wdata_q;
  // transfer sequencing: drained writes always win over a pending read, so reads see prior writes
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_pend_d  = rd_pend_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!wr_empty) begin
          state_d = WRITE;
          req_d   = 1'b1;
          we_d    = 1'b1;
          wdata_d = head;
        end else if (rd_pend_q) begin
          state_d = READ;
          req_d   = 1'b1;
          we_d    = 1'b0;
        end
      end
      WRITE: begin
        if (ack) begin
          pop     = 1'b1;
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      READ: begin
        if (ack) begin
          rd_data_d  = mem.rdata;
          rd_valid_d = 1'b1;
          rd_pend_d  = 1'b0;
          req_d      = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rd_start && !rd_pend_q && state_q != READ) begin
      rd_pend_d  = 1'b1;
      rd_valid_d = 1'b0;
    end
  end
  // FSM and registered outputs; reset abandons any in-flight transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_pend_q  <= rd_pend_d;
    end
  end
endmodule

// File: tb/tb_mdr_buffered.sv
// tb_mdr_buffered: random and directed traffic checked against a queue-based model of posted writes and reads
module tb_mdr_buffered;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_oe = 1'b0, wr_load = 1'b0, rd_start = 1'b0;
  logic        drv_en = 1'b1;
  logic [15:0] drv_val = '0;
  logic        rd_valid, wr_full, wr_empty, wr_ovf, busy;
  wire  [15:0] bus;
  mdr_buffered_if #(.DATA_W(16)) m ();
  assign bus = drv_en ? drv_val : 16'bz;
  mdr_buffered #(.DATA_W(16), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .bus_oe   (bus_oe),
    .wr_load  (wr_load),
    .rd_start (rd_start),
    .rd_valid (rd_valid),
    .wr_full  (wr_full),
    .wr_empty (wr_empty),
    .wr_ovf   (wr_ovf),
    .busy     (busy),
    .mem      (m)
  );
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0;
  logic [15:0] wq[$];
  logic [15:0] exp_rd;
  bit exp_valid, exp_ovf, outst;
  int pushes, writes_done, writes_needed, reads_acc, reads_fired;
  bit prev_req, prev_we, prev_fire;
  logic [15:0] prev_wd;
  bit ack_hold, rnd_dly, rd_fix_en;
  int ack_dly, wait_cnt;
  logic [15:0] rd_fix;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    wq.delete();
    exp_rd = '0; exp_valid = 0; exp_ovf = 0; outst = 0;
    pushes = 0; writes_done = 0; writes_needed = 0; reads_acc = 0; reads_fired = 0;
    prev_req = 0; prev_we = 0; prev_fire = 0; prev_wd = '0; wait_cnt = 0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    wr_load = 0; rd_start = 0; bus_oe = 0; drv_en = 1; m.ack = 0; m.rdata = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic step(input bit ld, input logic [15:0] v, input bit rs, input bit oe);
    bit req_s, we_s, fire, outst_pre;
    logic [15:0] wd_s, rd_s, pv;
    wr_load = ld; rd_start = rs; bus_oe = oe; drv_en = !oe; drv_val = v;
    if (m.req) begin
      m.ack = !ack_hold && wait_cnt >= ack_dly;
      wait_cnt++;
    end else begin
      m.ack = ($urandom_range(0, 5) == 0);
      wait_cnt = 0;
    end
    m.rdata = rd_fix_en ? rd_fix : 16'($urandom);
    #1;
    check("wr_full", 32'(wr_full), 32'(wq.size() == DEPTH));
    check("wr_empty", 32'(wr_empty), 32'(wq.size() == 0));
    check("wr_ovf", 32'(wr_ovf), 32'(exp_ovf));
    check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    check("busy", 32'(busy), 32'(outst || wq.size() != 0));
    check("bus", 32'(bus), 32'(oe ? exp_rd : v));
    if (prev_fire) check("req_gap", 32'(m.req), 32'(0));
    else if (prev_req) begin
      check("req_hold", 32'(m.req), 32'(1));
      check("we_hold", 32'(m.we), 32'(prev_we));
      if (prev_we) check("wdata_hold", 32'(m.wdata), 32'(prev_wd));
    end
    req_s = m.req; we_s = m.we; wd_s = m.wdata; rd_s = m.rdata;
    fire = req_s & m.ack;
    pv = oe ? exp_rd : v;
    outst_pre = outst;
    @(posedge clk);
    if (fire && we_s) begin
      check("wr_xfer_expected", 32'(wq.size() != 0), 32'(1));
      if (wq.size() != 0) begin
        check("wdata", 32'(wd_s), 32'(wq[0]));
        void'(wq.pop_front());
      end
      writes_done++;
    end
    if (fire && !we_s) begin
      check("rd_xfer_expected", 32'(outst_pre), 32'(1));
      check("rd_after_wr", 32'(writes_done >= writes_needed), 32'(1));
      exp_rd = rd_s; exp_valid = 1; outst = 0; reads_fired++;
    end
    if (ld) begin
      if (wq.size() < DEPTH) begin
        wq.push_back(pv);
        pushes++;
      end else exp_ovf = 1;
    end
    if (rs && !outst_pre) begin
      outst = 1; exp_valid = 0; writes_needed = pushes; reads_acc++;
    end
    prev_req = req_s; prev_we = we_s; prev_wd = wd_s; prev_fire = fire;
    if (fire) begin
      wait_cnt = 0;
      if (rnd_dly) ack_dly = $urandom_range(0, 3);
    end
    @(negedge clk);
  endtask
  task automatic drain();
    bit done;
    ack_hold = 0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (!busy && wq.size() == 0 && !outst) done = 1;
      else step(0, 16'($urandom), 0, 0);
    end
    check("drain_done", 32'(busy || wq.size() != 0 || outst), 32'(0));
  endtask
  initial begin
    int r0, w0;
    ack_hold = 0; rnd_dly = 0; ack_dly = 0; rd_fix_en = 0; rd_fix = '0;
    m.ack = 0; m.rdata = '0;
    do_reset();
    check("rst_req", 32'(m.req), 32'(0));
    check("rst_we", 32'(m.we), 32'(0));
    check("rst_wdata", 32'(m.wdata), 32'(0));
    check("rst_empty", 32'(wr_empty), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    step(0, 16'h0, 0, 1);
    step(0, 16'h0, 1, 0);
    check("lat_req_c1", 32'(m.req), 32'(0));
    step(0, 16'h0, 0, 0);
    check("lat_req_c2", 32'(m.req), 32'(1));
    step(0, 16'h0, 0, 0);
    check("lat_valid_c3", 32'(rd_valid), 32'(1));
    ack_dly = 1;
    w0 = writes_done;
    step(1, 16'hA5A5, 0, 0);
    step(1, 16'h1234, 0, 0);
    drain();
    check("t2_writes", 32'(writes_done - w0), 32'(2));
    check("t2_empty", 32'(wr_empty), 32'(1));
    rd_fix_en = 1; rd_fix = 16'hBEEF; ack_dly = 0;
    step(1, 16'h0001, 0, 0);
    step(0, 16'h0, 1, 0);
    drain();
    check("t3_valid", 32'(rd_valid), 32'(1));
    bus_oe = 1; drv_en = 0; #1;
    check("t3_bus", 32'(bus), 32'(16'hBEEF));
    bus_oe = 0; drv_en = 1;
    do_reset();
    ack_hold = 1;
    for (int i = 0; i < 4; i++) step(1, 16'(16'h1100 + i), 0, 0);
    check("t5_full", 32'(wr_full), 32'(1));
    ack_hold = 0;
    step(1, 16'h2222, 0, 0);
    check("t5_still_full", 32'(wr_full), 32'(1));
    check("t5_ovf", 32'(wr_ovf), 32'(0));
    drain();
    do_reset();
    ack_hold = 1;
    w0 = writes_done;
    for (int i = 0; i < 5; i++) step(1, 16'(16'h3300 + i), 0, 0);
    check("t4_full", 32'(wr_full), 32'(1));
    check("t4_ovf", 32'(wr_ovf), 32'(1));
    drain();
    check("t4_writes", 32'(writes_done - w0), 32'(4));
    rd_fix = 16'h00FF;
    r0 = reads_fired;
    ack_hold = 1;
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 0, 0);
    step(0, 16'h0, 0, 0);
    step(0, 16'h0, 1, 0);
    drain();
    check("t6_one_read", 32'(reads_fired - r0), 32'(1));
    bus_oe = 1; drv_en = 0; #1;
    check("t6_bus", 32'(bus), 32'(16'h00FF));
    bus_oe = 0; drv_en = 1; #1;
    check("t6_bus_released", 32'(bus), 32'(drv_val));
    rd_fix_en = 0;
    ack_hold = 1;
    step(1, 16'h5555, 0, 0);
    step(0, 16'h0, 0, 0);
    check("t1_req_before", 32'(m.req), 32'(1));
    #2 reset = 1'b1;
    #1;
    check("t1_req", 32'(m.req), 32'(0));
    check("t1_empty", 32'(wr_empty), 32'(1));
    check("t1_valid", 32'(rd_valid), 32'(0));
    check("t1_idle", 32'(busy), 32'(0));
    ack_hold = 0;
    do_reset();
    rnd_dly = 1;
    for (int b = 0; b < 150; b++) begin
      ack_hold = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 20; i++)
        step($urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end
    drain();
    check("rand_reads", 32'(reads_fired), 32'(reads_acc));
    check("rand_writes", 32'(writes_done), 32'(pushes));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
